mac_pack_engine: RTL and testbench

MAC_PACK_ENGINE -- requirements
Module: mac_pack_engine

---
 rtl/cnn_pkg.sv | 22 ++
 rtl/mac_tree.sv | 46 ++++
 rtl/mac_pack_engine.sv | 156 +++++++++++++++
 tb/tb_mac_pack_engine.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared defaults and the saturation helper for the CNN datapath blocks.
package cnn_pkg;

   localparam int unsigned LANES_DEF = 4;
   localparam int unsigned DW_DEF    = 16;
   localparam int unsigned ACC_W_DEF = 40;
   localparam int unsigned PACK_DEF  = 4;
   localparam int unsigned DEPTH_DEF = 256;
   localparam int unsigned SHIFT_W   = 5;

   typedef enum logic [1:0] {SatNone, SatHigh, SatLow} sat_e;

   // Classifies a sign-extended value against the signed dw-bit range.
   function automatic sat_e sat_check(input logic signed [63:0] x, input int unsigned dw);
      logic signed [63:0] lim;
      lim = 64'sd1 <<< (dw - 1);
      if (x >= lim) return SatHigh;
      if (x < -lim) return SatLow;
      return SatNone;
   endfunction

endpackage

// File: rtl/mac_tree.sv
// Two-stage multiply/adder tree: registered lane products, then their registered signed sum.
module mac_tree
   import cnn_pkg::*;
#(
   parameter int unsigned LANES = LANES_DEF,
   parameter int unsigned DW    = DW_DEF
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               en,
   input  logic [LANES*DW-1:0]                ifm_vec,
   input  logic [LANES*DW-1:0]                w_vec,
   output logic signed [2*DW+$clog2(LANES):0] sum
);
   localparam int unsigned PW = 2 * DW;
   localparam int unsigned SW = PW + $clog2(LANES) + 1;

   logic signed [PW-1:0] prod_d [LANES];
   logic signed [PW-1:0] prod_q [LANES];
   logic signed [SW-1:0] sum_d;
   logic signed [SW-1:0] sum_q;

   always_comb begin
      sum_d = '0;
      for (int i = 0; i < LANES; i++) begin
         prod_d[i] = PW'($signed(ifm_vec[(LANES-1-i)*DW +: DW]))
                   * PW'($signed(w_vec[(LANES-1-i)*DW +: DW]));
         sum_d = sum_d + SW'(prod_q[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LANES; i++) begin
            prod_q[i] <= '0;
         end
         sum_q <= '0;
      end else if (en) begin
         prod_q <= prod_d;
         sum_q  <= sum_d;
      end
   end

   assign sum = sum_q;

endmodule

// File: rtl/mac_pack_engine.sv
// Pipelined MAC engine: accumulates per-neuron sums, shifts/saturates them and packs
// PACK results per output word with a wrapping buffer address.
module mac_pack_engine
   import cnn_pkg::*;
#(
   parameter int unsigned LANES = LANES_DEF,
   parameter int unsigned DW    = DW_DEF,
   parameter int unsigned ACC_W = ACC_W_DEF,
   parameter int unsigned PACK  = PACK_DEF,
   parameter int unsigned DEPTH = DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [SHIFT_W-1:0]       shift,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [LANES*DW-1:0]      ifm_vec,
   input  logic [LANES*DW-1:0]      w_vec,
   input  logic                     in_last,
   input  logic                     plane_last,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [PACK*DW-1:0]       out_word,
   output logic [PACK-1:0]          out_wea,
   output logic [$clog2(DEPTH)-1:0] out_addr
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned SW = 2 * DW + $clog2(LANES) + 1;
   localparam int unsigned IW = (PACK > 1) ? $clog2(PACK) : 1;

   logic                    stall;
   logic                    accept;
   logic                    v1_q, v2_q, v3_q;
   logic                    l1_q, l2_q, l3_q;
   logic                    p1_q, p2_q, p3_q;
   logic                    first_q;
   logic signed [SW-1:0]    tree_sum;
   logic signed [ACC_W-1:0] sum_ext;
   logic signed [ACC_W-1:0] acc_q;
   logic signed [ACC_W-1:0] shifted;
   logic [DW-1:0]           res;
   logic [PACK*DW-1:0]      pack_q, pack_d, word_q;
   logic [PACK-1:0]         wea_q, wea_d, out_wea_q;
   logic [IW-1:0]           idx_q, idx_d;
   logic                    full_q, full_d;
   logic                    out_valid_q;
   logic [AW-1:0]           addr_q;

   assign stall    = out_valid_q && !out_ready;
   assign in_ready = !stall || start;
   assign accept   = in_valid && !stall && !start;

   mac_tree #(
      .LANES (LANES),
      .DW    (DW)
   ) u_tree (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (!stall),
      .ifm_vec (ifm_vec),
      .w_vec   (w_vec),
      .sum     (tree_sum)
   );

   assign sum_ext = ACC_W'(tree_sum);

   always_comb begin
      shifted = acc_q >>> shift;
      res     = shifted[DW-1:0];
      case (sat_check(64'(shifted), DW))
         SatHigh: res = {1'b0, {(DW-1){1'b1}}};
         SatLow:  res = {1'b1, {(DW-1){1'b0}}};
         default: res = shifted[DW-1:0];
      endcase
   end

   // A full pack moves to the output register this cycle, so the next result lands in slot 0.
   always_comb begin
      int slot;
      pack_d = full_q ? '0 : pack_q;
      wea_d  = full_q ? '0 : wea_q;
      slot   = int'(idx_q);
      idx_d  = idx_q;
      full_d = 1'b0;
      if (v3_q && l3_q) begin
         pack_d[(PACK-1-slot)*DW +: DW] = res;
         wea_d[PACK-1-slot]             = 1'b1;
         if (slot == PACK - 1 || p3_q) begin
            full_d = 1'b1;
            idx_d  = '0;
         end else begin
            idx_d = IW'(slot + 1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         {v1_q, v2_q, v3_q, l1_q, l2_q, l3_q, p1_q, p2_q, p3_q} <= '0;
         first_q     <= 1'b1;
         acc_q       <= '0;
         pack_q      <= '0;
         wea_q       <= '0;
         idx_q       <= '0;
         full_q      <= 1'b0;
         out_valid_q <= 1'b0;
         word_q      <= '0;
         out_wea_q   <= '0;
         addr_q      <= '0;
      end else if (start) begin
         {v1_q, v2_q, v3_q, l1_q, l2_q, l3_q, p1_q, p2_q, p3_q} <= '0;
         first_q     <= 1'b1;
         acc_q       <= '0;
         pack_q      <= '0;
         wea_q       <= '0;
         idx_q       <= '0;
         full_q      <= 1'b0;
         out_valid_q <= 1'b0;
         addr_q      <= '0;
      end else if (!stall) begin
         v1_q <= accept;
         l1_q <= in_last;
         p1_q <= in_last && plane_last;
         v2_q <= v1_q;
         l2_q <= l1_q;
         p2_q <= p1_q;
         v3_q <= v2_q;
         l3_q <= l2_q;
         p3_q <= p2_q;
         if (v2_q) begin
            acc_q   <= first_q ? sum_ext : acc_q + sum_ext;
            first_q <= l2_q;
         end
         pack_q <= pack_d;
         wea_q  <= wea_d;
         idx_q  <= idx_d;
         full_q <= full_d;
         // Not stalled, so a valid word here is being accepted.
         if (out_valid_q) begin
            addr_q <= (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
         end
         out_valid_q <= full_q;
         if (full_q) begin
            word_q    <= pack_q;
            out_wea_q <= wea_q;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_word  = word_q;
   assign out_wea   = out_wea_q;
   assign out_addr  = addr_q;

endmodule

// File: tb/tb_mac_pack_engine.sv
// Directed bench for mac_pack_engine with a behavioural reference model and output scoreboard.
module tb_mac_pack_engine;

   localparam int unsigned DEPTH = 256;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [4:0]  shift = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] ifm_vec = '0;
   logic [63:0] w_vec = '0;
   logic        in_last = 1'b0;
   logic        plane_last = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [63:0] out_word;
   logic [3:0]  out_wea;
   logic [7:0]  out_addr;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [63:0] word;
      logic [3:0]  wea;
      logic [7:0]  addr;
   } exp_t;
   exp_t sb[$];
   exp_t mon_e;

   // Reference model state
   logic signed [39:0] m_acc = '0;
   bit                 m_first = 1'b1;
   logic [63:0]        m_pack = '0;
   logic [3:0]         m_wea = '0;
   int                 m_idx = 0;
   int                 m_addr = 0;

   always #5 clk = ~clk;

   mac_pack_engine dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .shift      (shift),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .ifm_vec    (ifm_vec),
      .w_vec      (w_vec),
      .in_last    (in_last),
      .plane_last (plane_last),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_word   (out_word),
      .out_wea    (out_wea),
      .out_addr   (out_addr)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      m_acc = '0; m_first = 1'b1; m_pack = '0; m_wea = '0; m_idx = 0; m_addr = 0;
   endtask

   task automatic model_beat(input logic [63:0] ifm, input logic [63:0] w,
                             input bit last, input bit plane);
      longint      s;
      longint      v;
      logic [15:0] r;
      s = 0;
      for (int l = 0; l < 4; l++) begin
         s += longint'($signed(ifm[(3-l)*16 +: 16])) * longint'($signed(w[(3-l)*16 +: 16]));
      end
      m_acc   = m_first ? 40'(s) : m_acc + 40'(s);
      m_first = last;
      if (last) begin
         v = longint'(m_acc) >>> shift;
         if (v > 32767) v = 32767;
         if (v < -32768) v = -32768;
         r = v[15:0];
         m_pack[(3-m_idx)*16 +: 16] = r;
         m_wea[3-m_idx] = 1'b1;
         if (m_idx == 3 || plane) begin
            sb.push_back('{word: m_pack, wea: m_wea, addr: 8'(m_addr)});
            m_addr = (m_addr + 1) % DEPTH;
            m_pack = '0; m_wea = '0; m_idx = 0;
         end else begin
            m_idx++;
         end
      end
   endtask

   // Called just after a rising edge; returns just after the edge that accepts the beat.
   task automatic beat(input logic [63:0] ifm, input logic [63:0] w,
                       input bit last, input bit plane);
      int n = 0;
      in_valid = 1'b1; ifm_vec = ifm; w_vec = w; in_last = last; plane_last = plane;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("in_accept_timeout", 64'(in_ready), 64'd1);
      else model_beat(ifm, w, last, plane);
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0; plane_last = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 100);
      if (!out_valid) chk("out_valid_timeout", 64'(out_valid), 64'd1);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 64'(sb.size()), 64'd0);
      @(posedge clk); #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      chk("in_ready_start", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      start = 1'b0;
      model_clear();
   endtask

   function automatic logic [63:0] rvec(input int unsigned hi);
      logic [63:0] r;
      for (int i = 0; i < 4; i++) r[i*16 +: 16] = 16'($urandom_range(0, hi));
      return r;
   endfunction

   // Scoreboard: every accepted output word is compared against the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk("sb_word", out_word, mon_e.word);
            chk("sb_wea", 64'(out_wea), 64'(mon_e.wea));
            chk("sb_addr", 64'(out_addr), 64'(mon_e.addr));
         end
      end
   end

   initial begin
      int n;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_word", out_word, 64'd0);
      chk("rst_out_wea", 64'(out_wea), 64'd0);
      chk("rst_out_addr", 64'(out_addr), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Four single-beat neurons fill one word
      for (int k = 0; k < 4; k++) beat(64'h0001_0001_0001_0001, 64'h0001_0002_0003_0004, 1, 0);
      wait_valid(n);
      chk("latency", 64'(n), 64'd5);
      chk("w0_word", out_word, 64'h000A_000A_000A_000A);
      chk("w0_wea", 64'(out_wea), 64'hF);
      chk("w0_addr", 64'(out_addr), 64'd0);
      @(posedge clk); #1;

      // Saturation both ways, flushed by plane_last
      for (int k = 0; k < 3; k++) beat(64'h7FFF_7FFF_7FFF_7FFF, 64'h7FFF_7FFF_7FFF_7FFF, k == 2, 0);
      for (int k = 0; k < 3; k++) beat(64'h7FFF_7FFF_7FFF_7FFF, 64'h8000_8000_8000_8000, k == 2, k == 2);
      wait_valid(n);
      chk("sat_word", out_word, 64'h7FFF_8000_0000_0000);
      chk("sat_wea", 64'(out_wea), 64'hC);
      chk("sat_addr", 64'(out_addr), 64'd1);
      @(posedge clk); #1;

      // Partial word with arithmetic shift: -1800>>>3 = -225, 200000>>>3 = 25000
      shift = 5'd3;
      beat(64'h0064_FF38_012C_FE70, 64'h0005_0006_0007_0008, 1, 0);
      beat(64'h03E8_03E8_03E8_03E8, 64'h000A_0014_001E_0028, 0, 0);
      beat(64'h03E8_03E8_03E8_03E8, 64'h000A_0014_001E_0028, 1, 1);
      wait_valid(n);
      chk("plane_word", out_word, 64'hFF1F_61A8_0000_0000);
      chk("plane_wea", 64'(out_wea), 64'hC);
      chk("plane_addr", 64'(out_addr), 64'd2);
      @(posedge clk); #1;

      // Back-pressure while streaming
      shift = 5'd5;
      fork
         begin
            for (int k = 0; k < 16; k++) beat(rvec(16'hFFFF), rvec(16'hFFFF), 1, 0);
         end
         begin
            logic [63:0] held;
            out_ready = 1'b0;
            wait_valid(n);
            held = out_word;
            for (int c = 0; c < 10; c++) begin
               @(negedge clk);
               chk("stall_in_ready", 64'(in_ready), 64'd0);
               chk("stall_valid", 64'(out_valid), 64'd1);
               chk("stall_word", out_word, held);
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      drain();

      // Address wrap over DEPTH+1 words
      shift = 5'd0;
      do_start();
      for (int k = 0; k < (DEPTH + 1) * 4; k++) beat(rvec(255), rvec(255), 1, 0);
      drain();
      chk("wrap_next_addr", 64'(out_addr), 64'd1);

      // Start mid-neuron discards the partial pack and in-flight beats
      beat(64'h0100_0100_0100_0100, 64'h0100_0100_0100_0100, 1, 0);
      beat(64'h0100_0100_0100_0100, 64'h0100_0100_0100_0100, 0, 0);
      beat(64'h0100_0100_0100_0100, 64'h0100_0100_0100_0100, 0, 0);
      do_start();
      for (int k = 0; k < 4; k++) beat(64'h0002_0002_0002_0002, 64'h0001_0001_0001_0001, 1, 0);
      wait_valid(n);
      chk("start_word", out_word, 64'h0008_0008_0008_0008);
      chk("start_addr", 64'(out_addr), 64'd0);
      @(posedge clk); #1;

      // Reset during a stalled output
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) beat(64'h0003_0003_0003_0003, 64'h0001_0001_0001_0001, 1, 0);
      wait_valid(n);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 64'(out_valid), 64'd0);
      chk("arst_out_word", out_word, 64'd0);
      chk("arst_out_wea", 64'(out_wea), 64'd0);
      chk("arst_out_addr", 64'(out_addr), 64'd0);
      chk("arst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      sb.delete();
      model_clear();
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) beat(64'h0001_0001_0001_0001, 64'h0001_0001_0001_0001, 1, 0);
      wait_valid(n);
      chk("post_rst_word", out_word, 64'h0004_0004_0004_0004);
      chk("post_rst_addr", 64'(out_addr), 64'd0);
      @(posedge clk); #1;
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
